fft_sdf_ctrl: RTL

Central sequencer for the radix-2 single-path delay-feedback (SDF) FFT pipeline of LOG2N cascaded butterfly stages. Stage s has delay depth D_s = N/2^(s+1) plus one output register.
- Accepts a gapless sample stream and issues each stage's counter enable and butterfly-mode bit.
- Drives the twiddle ROM address for each inter-stage multiplier.
- Zero-pads to flush the final frame and tags output samples with valid, first, last and bit-reversed index.

---
 rtl/fft_sdf_ctrl_if.sv | 41 ++++
 rtl/fft_sdf_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fft_sdf_ctrl_if.sv
// fft_sdf_ctrl_if: sample handshake, per-stage control and output tagging bundle of the SDF FFT sequencer
// Optional frame counter port is present when FFT_FRAME_CNT_EN is defined.
interface fft_sdf_ctrl_if #(
  parameter int LOG2N = 5
);
  logic                         in_valid;
  logic                         in_ready;
  logic                         in_zero;
  logic [LOG2N-1:0]             cnt_en;
  logic [LOG2N-1:0]             stage_mode;
  logic [LOG2N*(LOG2N-1)-1:0]   tw_addr;
  logic                         out_valid;
  logic                         out_first;
  logic                         out_last;
  logic [LOG2N-1:0]             out_index;
  logic                         busy;
  logic                         gap_err;
`ifdef FFT_FRAME_CNT_EN
  logic [15:0]                  frame_cnt;
`endif

  // controller side
  modport master (
    input  in_valid,
    output in_ready, in_zero, cnt_en, stage_mode, tw_addr,
    output out_valid, out_first, out_last, out_index, busy, gap_err
`ifdef FFT_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  // sample source / datapath side
  modport slave (
    output in_valid,
    input  in_ready, in_zero, cnt_en, stage_mode, tw_addr,
    input  out_valid, out_first, out_last, out_index, busy, gap_err
`ifdef FFT_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/fft_sdf_ctrl.sv
// fft_sdf_ctrl: sequencer for a radix-2 SDF FFT pipeline (stage enables, butterfly modes, twiddle addresses, output tags)
// Define FFT_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module fft_sdf_ctrl #(
  parameter int N_POINT   = 32,
  parameter int LOG2N     = 5,
  parameter int STAGE_REG = 1
) (
  input logic            clk,
  input logic            rst,
  fft_sdf_ctrl_if.master bus
);
  localparam int L  = N_POINT - 1 + LOG2N * STAGE_REG;
  localparam int TW = LOG2N - 1;

  // cycle at which stage s sees the first token of a frame
  function automatic int off(input int s);
    int o = 0;
    for (int k = 0; k < s; k++) o += (N_POINT >> (k + 1)) + STAGE_REG;
    return o;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, PAD, TAIL} state_t;

  state_t             state, state_nx;
  logic [LOG2N-1:0]   cnt, cnt_nx;
  logic               tok, is_real, gap, gap_err;
  logic [L-1:0]       tok_sr, real_sr;
  logic [LOG2N-1:0]   idx, rev, cnt_en, mode;
  logic [LOG2N*TW-1:0] tw;

  // next state, sample/pad counting and input-side handshake
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    tok          = 1'b0;
    is_real      = 1'b0;
    gap          = 1'b0;
    bus.in_ready = 1'b0;
    bus.in_zero  = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        tok          = bus.in_valid;
        is_real      = bus.in_valid;
        state_nx     = bus.in_valid ? RUN : IDLE;
        cnt_nx       = bus.in_valid ? LOG2N'(1) : '0;
      end
      RUN: begin
        bus.in_ready = 1'b1;
        if (cnt == '0) begin
          tok      = bus.in_valid;
          is_real  = bus.in_valid;
          state_nx = bus.in_valid ? RUN : PAD;
          cnt_nx   = bus.in_valid ? LOG2N'(1) : '0;
        end else begin
          tok         = 1'b1;
          is_real     = 1'b1;
          gap         = !bus.in_valid;
          bus.in_zero = !bus.in_valid;
          cnt_nx      = cnt + LOG2N'(1);
        end
      end
      PAD: begin
        tok         = 1'b1;
        bus.in_zero = 1'b1;
        cnt_nx      = cnt + LOG2N'(1);
        state_nx    = &cnt ? TAIL : PAD;
      end
      TAIL: state_nx = (tok_sr == '0) ? IDLE : TAIL;
      default: state_nx = IDLE;
    endcase
  end

  // state, token pipes, output bin counter and sticky gap flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      tok_sr  <= '0;
      real_sr <= '0;
      idx     <= '0;
      gap_err <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      tok_sr  <= {tok_sr[L-2:0], tok};
      real_sr <= {real_sr[L-2:0], is_real};
      idx     <= real_sr[L-1] ? idx + LOG2N'(1) : idx;
      gap_err <= gap_err | gap;
    end
  end

  for (genvar s = 0; s < LOG2N; s++) begin : g_stage
    localparam int W = LOG2N - s;
    logic [W-1:0] c;
    if (s == 0) begin : g_first
      assign cnt_en[s] = tok;
    end else begin : g_later
      assign cnt_en[s] = tok_sr[off(s)-1];
    end
    // local butterfly counter, modulo twice the stage delay depth
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) c <= '0;
      else if (cnt_en[s]) c <= c + W'(1);
    end
    assign mode[s] = c[W-1];
    if (s < LOG2N - 1) begin : g_tw
      assign tw[s*TW +: TW] = c[W-1] ? TW'(c[W-2:0]) << s : '0;
    end
  end

  for (genvar b = 0; b < LOG2N; b++) begin : g_rev
    assign rev[b] = idx[LOG2N-1-b];
  end

  assign bus.cnt_en     = cnt_en;
  assign bus.stage_mode = mode;
  assign bus.tw_addr    = tw;
  assign bus.out_valid  = real_sr[L-1];
  assign bus.out_first  = real_sr[L-1] & (idx == '0);
  assign bus.out_last   = real_sr[L-1] & (&idx);
  assign bus.out_index  = rev;
  assign bus.busy       = (state != IDLE) | (|tok_sr);
  assign bus.gap_err    = gap_err;

`ifdef FFT_FRAME_CNT_EN
  // count frames as their final bin leaves the pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bus.frame_cnt <= '0;
    else if (bus.out_last) bus.frame_cnt <= bus.frame_cnt + 16'd1;
  end
`endif
endmodule
